serial_ripple_subtractor: RTL
=============================

Name: serial_ripple_subtractor

Overview:
Bit-serial, multi-cycle subtractor that computes D = A - B one bit per clock, LSB first, with a registered borrow. It is the down-count datapath of the visitor counter and the subtract-direction counterpart of the combinational 4-bit ripple carry adder. A start/ready/done handshake lets the exit-sensor controller issue one subtraction at a time and collect the difference, borrow-out and zero flag.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a subtraction; sampled only while ready=1
A  input  WIDTH  minuend; captured on the accepted start edge
B  input  WIDTH  subtrahend; captured on the accepted start edge
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse; D, Bout and zero are valid from this cycle
D  output  WIDTH  difference (A - B) mod 2^WIDTH
Bout  output  1  final borrow; 1 means A < B (underflow)
zero  output  1  1 when D == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; ready=1; done=0; D=0; Bout=0; zero=0; internal shift registers, borrow and bit counter cleared. Reset mid-operation aborts it; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE: ready=1. On a rising edge with start=1: latch A, B into operand shift registers; borrow<=0; bit counter<=0; go to SHIFT. start=0 stays in IDLE.
- SHIFT (exactly WIDTH cycles): ready=0. Per cycle, with a=opA[0], b=opB[0], br=borrow:
  diff = a ^ b ^ br; borrow_next = (~a & b) | (~(a ^ b) & br).
  diff shifts into the result register MSB (result shifts right); opA and opB shift right; counter increments. When the counter reaches WIDTH-1, go to DONE.
- DONE (one cycle): done=1; D<=result register; Bout<=final borrow; zero<=(result==0). Next edge returns to IDLE.
- Latency: start sampled at edge k; done high in the cycle after edge k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- D, Bout and zero are registered. They hold their values from DONE until the next DONE or reset. They do not change during SHIFT.
- start while ready=0 (SHIFT or DONE) is ignored. It is not queued.
- A and B may change freely after the accepting edge without affecting the result.
- Arithmetic is unsigned modulo 2^WIDTH. Bout is the true borrow out of bit WIDTH-1.
- Bit counter width is clog2(WIDTH). No overflow beyond WIDTH-1 is possible.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the counter-width function clog2, reused by future serial datapath blocks.
- One sub-module: full_subtractor (combinational; inputs a, b, bin; outputs diff, bout). It mirrors the existing full_adder cell. The FSM, shift registers and borrow flip-flop stay in the top module.

Test Plan:
- WIDTH=4, A=9, B=3, start pulse -> done exactly 6 cycles after the accepting edge; D=6, Bout=0, zero=0; ready low for 5 cycles.
- A=3, B=9 -> D=4'hA, Bout=1, zero=0. Also A=0, B=15 -> D=1, Bout=1.
- A=5, B=5 -> D=0, Bout=0, zero=1. Also A=15, B=0 -> D=15, Bout=0.
- Start 9-3, then pulse start with A=1, B=1 two cycles later (busy) -> second request ignored; only one done, D=6; D holds 6 while in IDLE.
- Assert rst_n low during SHIFT cycle 2 -> outputs immediately 0 and ready=1; no done pulse. A following 7-2 -> D=5.
- Back-to-back: start held high continuously with A=8, B=1 -> a new op is accepted in each IDLE cycle, one done every 6 cycles, each with D=7, Bout=0.
- Exhaustive sweep of all 256 (A, B) pairs at WIDTH=4 -> {Bout, D} equals (A - B) in 5-bit two's complement for every pair.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial datapath blocks: FSM state encoding
// and the counter-width helper.
package serial_ripple_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, with borrow out.
// Subtract-direction twin of the full_adder cell.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: D = A - B computed LSB first, one bit per clock,
// behind a start/ready/done handshake with registered results.
module serial_ripple_subtractor
   import serial_ripple_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             zero
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               borrow_q, borrow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               bout_q, bout_d;
   logic               zero_q, zero_d;

   logic               fs_diff;
   logic               fs_bout;

   full_subtractor u_full_subtractor (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .bin  (borrow_q),
      .diff (fs_diff),
      .bout (fs_bout)
   );

   always_comb begin
      // NOTE: every _d gets a hold default first, so no path leaves a signal unassigned and no latch is inferred.
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      d_d      = d_q;
      bout_d   = bout_q;
      zero_d   = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d    = A;
               opb_d    = B;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            res_d    = {fs_diff, res_q[WIDTH-1:1]};
            opa_d    = opa_q >> 1;
            opb_d    = opb_q >> 1;
            borrow_d = fs_bout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) state_d = DONE;
         end
         DONE: begin
            // Publish the finished difference; done rises together with it.
            done_d  = 1'b1;
            d_d     = res_q;
            bout_d  = borrow_q;
            zero_d  = (res_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         zero_q   <= zero_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign D     = d_q;
   assign Bout  = bout_q;
   assign zero  = zero_q;

endmodule
